// File: rtl/saph_pkg.sv
// Shared saph types and bit-count helpers for the pixel pack sequencer.
package saph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_DONE = 2'd2
    } saph_state_e;

    function automatic int saph_chan_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int saph_pos_bits(input int pack_width);
        return $clog2(pack_width);
    endfunction

    function automatic int saph_width_bits(input int unpack_width);
        return $clog2(unpack_width + 1);
    endfunction

    localparam int SAPH_POS_BITS   = saph_pos_bits(16);
    localparam int SAPH_WIDTH_BITS = saph_width_bits(8);

endpackage

// File: rtl/saph_num_pack.sv
// Keeps the top `width` MSBs of one channel and places them at bit `pos`.
// Purely combinational; no flow control.
module saph_num_pack
    import saph_pkg::*;
#(
    parameter int pack_width   = 16,
    parameter int unpack_width = 8,
    localparam int PB = saph_pos_bits(pack_width),
    localparam int WB = saph_width_bits(unpack_width)
) (
    input  logic [unpack_width-1:0] chan_dat,
    input  logic [PB-1:0]           pos,
    input  logic [WB-1:0]           width,
    output logic [pack_width-1:0]   packed_dat
);

    localparam int SW = WB + 1;
    localparam logic [SW-1:0] UW_L = SW'(unpack_width);

    logic [SW-1:0]                      rsh;
    logic [unpack_width-1:0]            msbs;
    logic [pack_width+unpack_width-1:0] wide;

    // width is already clamped to unpack_width, so rsh never underflows
    always_comb begin
        rsh        = UW_L - {1'b0, width};
        msbs       = chan_dat >> rsh;
        wide       = {{pack_width{1'b0}}, msbs} << pos;
        packed_dat = (width == '0) ? '0 : wide[pack_width-1:0];
    end

endmodule

// File: rtl/saph_pixel_pack_seq.sv
// Packs one multi-channel pixel into a single word, one channel per cycle.
// Latency: out_valid rises channels+1 cycles after acceptance; one pixel in flight.
// Backpressure: in_ready only in IDLE; DONE holds out_data until out_ready.
module saph_pixel_pack_seq
    import saph_pkg::*;
#(
    parameter int pack_width   = 16,
    parameter int unpack_width = 8,
    parameter int channels     = 4,
    localparam int CW = saph_chan_bits(channels),
    localparam int PB = saph_pos_bits(pack_width),
    localparam int WB = saph_width_bits(unpack_width)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_we,
    input  logic [CW-1:0]                    cfg_chan,
    input  logic [PB-1:0]                    cfg_pos,
    input  logic [WB-1:0]                    cfg_width,
    output logic                             cfg_busy,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [channels*unpack_width-1:0] in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [pack_width-1:0]            out_data
);

    // Counter runs one past the last channel to give the hand-off cycle into DONE
    localparam int CNTW = $clog2(channels + 1);
    localparam logic [WB-1:0] UW_MAX = WB'(unpack_width);

    saph_state_e             state_q, state_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [pack_width-1:0]   acc_q, acc_d;
    logic [pack_width-1:0]   out_data_q, out_data_d;
    logic [unpack_width-1:0] pix_q [channels];
    logic [unpack_width-1:0] pix_d [channels];
    logic [PB-1:0]           pos_q [channels];
    logic [PB-1:0]           pos_d [channels];
    logic [WB-1:0]           width_q [channels];
    logic [WB-1:0]           width_d [channels];

    logic [CW-1:0]           sel;
    logic [pack_width-1:0]   chan_packed;
    logic                    cfg_hit;
    logic                    last_pack;

    assign sel       = CW'(cnt_q);
    assign cfg_hit   = cfg_we && (state_q == ST_IDLE) && (int'(cfg_chan) < channels);
    assign last_pack = (int'(cnt_q) == channels);

    saph_num_pack #(
        .pack_width   (pack_width),
        .unpack_width (unpack_width)
    ) u_num_pack (
        .chan_dat   (pix_q[sel]),
        .pos        (pos_q[sel]),
        .width      (width_q[sel]),
        .packed_dat (chan_packed)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        pix_d      = pix_q;
        pos_d      = pos_q;
        width_d    = width_q;

        if (cfg_hit) begin
            pos_d[cfg_chan]   = cfg_pos;
            width_d[cfg_chan] = (cfg_width > UW_MAX) ? UW_MAX : cfg_width;
        end

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    for (int k = 0; k < channels; k++) begin
                        pix_d[k] = in_data[k*unpack_width +: unpack_width];
                    end
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_PACK;
                end
            end
            ST_PACK: begin
                if (last_pack) begin
                    out_data_d = acc_q;
                    state_d    = ST_DONE;
                end else begin
                    acc_d = acc_q | chan_packed;
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            for (int k = 0; k < channels; k++) begin
                pix_q[k]   <= '0;
                pos_q[k]   <= '0;
                width_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            pix_q      <= pix_d;
            pos_q      <= pos_d;
            width_q    <= width_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign cfg_busy  = (state_q != ST_IDLE);
    assign out_data  = out_data_q;

endmodule

// File: doc/saph_pixel_pack_seq.md
SAPH_PIXEL_PACK_SEQ -- requirements
Module: saph_pixel_pack_seq

Interface
REQ-001 Parameter pack_width, default 16: width of the packed output word, 2+.
REQ-002 Parameter unpack_width, default 8: width of each unpacked channel, 2+.
REQ-003 Parameter channels, default 4: number of channels per pixel, 1+.
REQ-004 clk  in  1  the only clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 cfg_we  in  1  configuration write strobe.
REQ-007 cfg_chan  in  $clog2(channels) (min 1)  channel index being configured.
REQ-008 cfg_pos  in  $clog2(pack_width)  packed bit position for that channel.
REQ-009 cfg_width  in  $clog2(unpack_width+1)  packed bit width for that channel.
REQ-010 cfg_busy  out  1  high whenever the state is not IDLE; configuration writes are dropped.
REQ-011 in_valid  in  1  unpacked pixel offered.
REQ-012 in_ready  out  1  pixel accepted when in_valid and in_ready are both high.
REQ-013 in_data  in  channels*unpack_width  channel k occupies bits [k*unpack_width +: unpack_width].
REQ-014 out_valid  out  1  packed word available.
REQ-015 out_ready  in  1  packed word consumed when out_valid and out_ready are both high.
REQ-016 out_data  out  pack_width  packed word.

Function
REQ-017 The FSM SHALL have three states: IDLE, PACK, DONE.
REQ-018 in_ready SHALL be high only in IDLE; out_valid SHALL be high only in DONE.
REQ-019 An input handshake in IDLE SHALL latch in_data, clear the accumulator, set the channel counter to 0, and move to PACK.
REQ-020 Each PACK cycle SHALL OR the packed value of the current channel into the accumulator and increment the counter; after channel channels-1 the FSM SHALL move to DONE.
REQ-021 Packed value of a channel SHALL be (chan >> (unpack_width - width)) << pos, truncated to pack_width bits; width 0 SHALL contribute 0.
REQ-022 A cfg_width write above unpack_width SHALL be stored as unpack_width.
REQ-023 Overlapping fields SHALL be OR-combined; no priority between channels.
REQ-024 Latency: out_valid SHALL rise exactly channels+1 cycles after the accepting edge.
REQ-025 In DONE, out_data SHALL stay stable while out_ready is low; an output handshake SHALL return the FSM to IDLE, so at most one pixel is in flight.
REQ-026 A cfg_we in IDLE SHALL update the addressed channel's registers at the same edge.
REQ-027 If cfg_we and an input handshake occur on the same edge, the write SHALL take effect and the accepted pixel SHALL use the new configuration.
REQ-028 A cfg_we outside IDLE SHALL have no effect.
REQ-029 A cfg_chan value of channels or more SHALL be ignored.

Reset
REQ-030 rst SHALL force IDLE, the counter to 0, the accumulator and out_data to 0, out_valid to 0, and in_ready to 1 on the next cycle.
REQ-031 rst SHALL clear every channel's pos and width to 0.
REQ-032 rst asserted during PACK or DONE SHALL discard the in-flight pixel without emitting it.

Structure
REQ-033 The FSM state enum SHALL live in the shared saph package, together with helper constants for the pos and width bit counts.
REQ-034 A single combinational instance of the existing saph_num_pack sub-module SHALL be time-shared across channels, indexed by the counter.

Verification
REQ-035 Config ch0 pos11/w5, ch1 pos5/w6, ch2 pos0/w5, ch3 w0; pixel {0x00,0x00,0x80,0xFF} -> out_data 0xFC00 exactly 5 cycles after acceptance.
REQ-036 out_ready held low for 10 cycles in DONE -> out_data constant, in_ready low, and a new in_valid is not accepted until the output handshake.
REQ-037 cfg_we during PACK setting ch0 width 0 -> current and next pixel still use the old ch0 width; a write in IDLE then takes effect.
REQ-038 cfg_width 15 with unpack_width 8 -> behaves as width 8; ch0 pos 12/w8 with data 0xAB -> out_data 0xB000 (truncated).
REQ-039 rst pulsed in the second PACK cycle -> next cycle IDLE, out_valid 0, in_ready 1, all configuration zero, and no output emitted.
REQ-040 cfg_we plus input handshake on the same edge -> the pixel packs with the newly written configuration.
